spi_initiator: RTL and testbench

- SPI mode-0 initiator (controller) that drives sck, sdo and cs_n, and samples sdi.
- It is the other end of the SPI responder interface of the FPGA top: it models or replaces the MCU side for loopback, self-test and FPGA-to-FPGA links.
- It shifts one DATA_W-bit word per transfer, MSB first, full duplex.
- Parallel side is a start/busy/done handshake.

---
 rtl/spi_initiator_if.sv | 13 +
 rtl/spi_initiator.sv | 141 ++++++++++++++
 tb/tb_spi_initiator.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_initiator_if.sv
// Parallel-side handshake for the SPI initiator: start/tx_data in, busy/done/rx_data out.
interface spi_initiator_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;

  modport master (output start, tx_data, input  busy, done, rx_data);
  modport slave  (input  start, tx_data, output busy, done, rx_data);
endinterface

// File: rtl/spi_initiator.sv
// SPI mode-0 initiator: one DATA_W-bit full-duplex word per transfer, MSB first.
// sck/cs_n/sdo are registered so they never glitch.
module spi_initiator #(
  parameter int DATA_W = 16,
  parameter int CLKDIV = 4
) (
  input  logic            clk,
  input  logic            reset,
  spi_initiator_if.slave  bus,
  output logic            sck,
  output logic            sdo,
  input  logic            sdi,
  output logic            cs_n
);
  localparam int CNT_W = $clog2(2*CLKDIV + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] PH_END = CNT_W'(CLKDIV - 1);
  // Trailing low: one sck low phase, CLKDIV of cs_n hold, then one settle
  // cycle, so done lands (2*DATA_W+2)*CLKDIV+1 edges after start.
  localparam logic [CNT_W-1:0] TR_END = CNT_W'(2*CLKDIV);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL, DONE} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [BIT_W-1:0]  bits, bits_d;
  logic [DATA_W-1:0] tx_sh, tx_sh_d, rx_sh, rx_sh_d, rx_q, rx_d;
  logic              sck_d, sdo_d, cs_n_d, busy_q, busy_d, done_q, done_d;

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      bits   <= '0;
      tx_sh  <= '0;
      rx_sh  <= '0;
      rx_q   <= '0;
      sck    <= 1'b0;
      sdo    <= 1'b0;
      cs_n   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      bits   <= bits_d;
      tx_sh  <= tx_sh_d;
      rx_sh  <= rx_sh_d;
      rx_q   <= rx_d;
      sck    <= sck_d;
      sdo    <= sdo_d;
      cs_n   <= cs_n_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bits_d  = bits;
    tx_sh_d = tx_sh;
    rx_sh_d = rx_sh;
    rx_d    = rx_q;
    sck_d   = sck;
    sdo_d   = sdo;
    cs_n_d  = cs_n;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_d = IDLE;
        sdo_d   = 1'b0;
        // Accepting in DONE gives back-to-back words with one cs_n-high cycle.
        if (bus.start) begin
          state_d = LEAD;
          tx_sh_d = bus.tx_data;
          sdo_d   = bus.tx_data[DATA_W-1];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bits_d  = '0;
        end
      end
      LEAD: begin
        if (cnt == PH_END) begin
          state_d = HIGH;
          cnt_d   = '0;
          sck_d   = 1'b1;
          rx_sh_d = {rx_sh[DATA_W-2:0], sdi};
          bits_d  = BIT_W'(1);
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (cnt == PH_END) begin
          cnt_d = '0;
          sck_d = 1'b0;
          if (bits < BIT_W'(DATA_W)) begin
            state_d = LOW;
            tx_sh_d = {tx_sh[DATA_W-2:0], 1'b0};
            sdo_d   = tx_sh[DATA_W-2];
          end else begin
            state_d = TRAIL;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      LOW: begin
        if (cnt == PH_END) begin
          state_d = HIGH;
          cnt_d   = '0;
          sck_d   = 1'b1;
          rx_sh_d = {rx_sh[DATA_W-2:0], sdi};
          bits_d  = bits + BIT_W'(1);
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      TRAIL: begin
        if (cnt == TR_END) begin
          state_d = DONE;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rx_d    = rx_sh;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_spi_initiator.sv
// Directed bench: loopback, mode-0 responder, timing, back-to-back, reset and start-while-busy.
module tb_spi_initiator;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cmp = 0;
  int errs = 0;

  // DUT under most tests: default CLKDIV=4, sdi from loopback or responder model
  spi_initiator_if #(.DATA_W(16)) bus ();
  logic sck, sdo, sdi, cs_n, loop;
  spi_initiator #(.DATA_W(16), .CLKDIV(4)) u_dut (
    .clk(clk), .reset(reset), .bus(bus), .sck(sck), .sdo(sdo), .sdi(sdi), .cs_n(cs_n));

  // Second DUT with CLKDIV=2, hard loopback
  spi_initiator_if #(.DATA_W(16)) bus2 ();
  logic sck2, sdo2, cs_n2;
  spi_initiator #(.DATA_W(16), .CLKDIV(2)) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .sck(sck2), .sdo(sdo2), .sdi(sdo2), .cs_n(cs_n2));

  // Mode-0 responder: shift out on sck fall, capture on sck rise
  logic [15:0] r_out = 16'h0000;
  logic [15:0] r_in  = 16'h0000;
  logic sdo_prev = 1'b0;
  int sdo_unstable = 0;
  assign sdi = loop ? sdo : r_out[15];
  always @(negedge cs_n) r_out <= 16'h1234;
  always @(negedge sck) if (!cs_n) r_out <= {r_out[14:0], 1'b0};
  always @(posedge sck) if (!cs_n) begin
    r_in <= {r_in[14:0], sdo};
    if (sdo !== sdo_prev) sdo_unstable++;
  end
  always @(negedge clk) sdo_prev <= sdo;

  task automatic capture(input logic [15:0] d, input int poke,
                         output int lat, output int rises, output int falls, output int bad_ph,
                         output int lead, output int cs_bad, output logic cs_done,
                         output logic done_next, output logic [15:0] rx);
    int n, last_t;
    logic prev;
    lat = -1; rises = 0; falls = 0; bad_ph = 0; lead = -1; cs_bad = 0;
    cs_done = 1'b0; done_next = 1'b1; last_t = 0; prev = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.tx_data = d;
    @(negedge clk); bus.start = 1'b0;
    n = 0;
    while (lat < 0 && n < 400) begin
      if (bus.done) begin lat = n; cs_done = cs_n; end
      else if (cs_n) cs_bad++;
      if (sck && !prev) begin
        rises++;
        if (rises == 1) lead = n; else if (n - last_t != 4) bad_ph++;
        last_t = n;
      end
      if (!sck && prev) begin
        falls++;
        if (n - last_t != 4) bad_ph++;
        last_t = n;
      end
      prev = sck;
      if (n == poke) begin bus.start = 1'b1; bus.tx_data = 16'h0000; end
      else if (n == poke + 1) bus.start = 1'b0;
      if (lat < 0) begin @(negedge clk); n++; end
    end
    bus.start = 1'b0;
    @(negedge clk);
    done_next = bus.done;
    rx = bus.rx_data;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    cmp++; if (sck !== 1'b0) begin errs++; $display("FAIL reset_sck got %b want 0", sck); end
    cmp++; if (cs_n !== 1'b1) begin errs++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
    cmp++; if (sdo !== 1'b0) begin errs++; $display("FAIL reset_sdo got %b want 0", sdo); end
    cmp++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    cmp++; if (bus.done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", bus.done); end
    cmp++; if (bus.rx_data !== 16'h0000) begin errs++; $display("FAIL reset_rx got %h want 0000", bus.rx_data); end
    reset = 1'b0;
  endtask

  task automatic test_loopback();
    int n, lat, rises, cs_bad;
    logic prev;
    n = 0; lat = -1; rises = 0; cs_bad = 0; prev = 1'b0;
    @(negedge clk); bus2.start = 1'b1; bus2.tx_data = 16'hA5C3;
    @(negedge clk); bus2.start = 1'b0;
    while (lat < 0 && n < 300) begin
      if (bus2.done) lat = n;
      else if (cs_n2) cs_bad++;
      if (sck2 && !prev) rises++;
      prev = sck2;
      if (lat < 0) begin @(negedge clk); n++; end
    end
    cmp++; if (lat !== 69) begin errs++; $display("FAIL loop_latency got %0d want 69", lat); end
    cmp++; if (rises !== 16) begin errs++; $display("FAIL loop_rises got %0d want 16", rises); end
    cmp++; if (bus2.rx_data !== 16'hA5C3) begin errs++; $display("FAIL loop_rx got %h want a5c3", bus2.rx_data); end
    cmp++; if (cs_bad !== 0) begin errs++; $display("FAIL loop_cs_low got %0d high cycles want 0", cs_bad); end
    @(negedge clk);
    cmp++; if (cs_n2 !== 1'b1) begin errs++; $display("FAIL loop_cs_after got %b want 1", cs_n2); end
  endtask

  task automatic test_responder();
    int lat, rises, falls, bad_ph, lead, cs_bad;
    logic cs_done, done_next;
    logic [15:0] rx;
    loop = 1'b0; sdo_unstable = 0;
    capture(16'hBEEF, -10, lat, rises, falls, bad_ph, lead, cs_bad, cs_done, done_next, rx);
    cmp++; if (r_in !== 16'hBEEF) begin errs++; $display("FAIL resp_rx_word got %h want beef", r_in); end
    cmp++; if (rx !== 16'h1234) begin errs++; $display("FAIL resp_rx_data got %h want 1234", rx); end
    cmp++; if (sdo_unstable !== 0) begin errs++; $display("FAIL resp_sdo_stable got %0d changes want 0", sdo_unstable); end
    loop = 1'b1;
  endtask

  task automatic test_timing();
    int lat, rises, falls, bad_ph, lead, cs_bad;
    logic cs_done, done_next;
    logic [15:0] rx;
    loop = 1'b1;
    capture(16'hC3A5, -10, lat, rises, falls, bad_ph, lead, cs_bad, cs_done, done_next, rx);
    cmp++; if (lat !== 137) begin errs++; $display("FAIL tim_latency got %0d want 137", lat); end
    cmp++; if (rises !== 16) begin errs++; $display("FAIL tim_rises got %0d want 16", rises); end
    cmp++; if (falls !== 16) begin errs++; $display("FAIL tim_falls got %0d want 16", falls); end
    cmp++; if (bad_ph !== 0) begin errs++; $display("FAIL tim_phase got %0d bad phases want 0", bad_ph); end
    cmp++; if (lead !== 4) begin errs++; $display("FAIL tim_lead got %0d want 4", lead); end
    cmp++; if (cs_bad !== 0) begin errs++; $display("FAIL tim_cs_low got %0d want 0", cs_bad); end
    cmp++; if (cs_done !== 1'b1) begin errs++; $display("FAIL tim_cs_at_done got %b want 1", cs_done); end
    cmp++; if (done_next !== 1'b0) begin errs++; $display("FAIL tim_done_width got %b want 0", done_next); end
    cmp++; if (rx !== 16'hC3A5) begin errs++; $display("FAIL tim_rx got %h want c3a5", rx); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    logic [15:0] got [3];
    int dt [3];
    int nd, cs_hi, n;
    words[0] = 16'h0001; words[1] = 16'h8000; words[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin dt[i] = 0; got[i] = 16'h0000; end
    nd = 0; cs_hi = 0; n = 0;
    loop = 1'b1;
    @(negedge clk); bus.start = 1'b1; bus.tx_data = words[0];
    @(negedge clk);
    while (nd < 3 && n < 500) begin
      if (bus.done) begin
        dt[nd] = n; got[nd] = bus.rx_data; nd++;
        if (nd < 3) bus.tx_data = words[nd]; else bus.start = 1'b0;
      end
      if (nd >= 1 && nd < 3 && cs_n) cs_hi++;
      if (nd < 3) begin @(negedge clk); n++; end
    end
    bus.start = 1'b0;
    cmp++; if (nd !== 3) begin errs++; $display("FAIL b2b_count got %0d want 3", nd); end
    cmp++; if (dt[0] !== 137) begin errs++; $display("FAIL b2b_first got %0d want 137", dt[0]); end
    cmp++; if (dt[1] - dt[0] !== 138) begin errs++; $display("FAIL b2b_gap1 got %0d want 138", dt[1] - dt[0]); end
    cmp++; if (dt[2] - dt[1] !== 138) begin errs++; $display("FAIL b2b_gap2 got %0d want 138", dt[2] - dt[1]); end
    for (int i = 0; i < 3; i++) begin
      cmp++; if (got[i] !== words[i]) begin errs++; $display("FAIL b2b_rx%0d got %h want %h", i, got[i], words[i]); end
    end
    cmp++; if (cs_hi !== 2) begin errs++; $display("FAIL b2b_cs_gap got %0d want 2", cs_hi); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n, rises, dones, lat, r, f, bad_ph, lead, cs_bad;
    logic prev, cs_done, done_next;
    logic [15:0] rx;
    n = 0; rises = 0; dones = 0; prev = 1'b0;
    loop = 1'b1;
    @(negedge clk); bus.start = 1'b1; bus.tx_data = 16'hFFFF;
    @(negedge clk); bus.start = 1'b0;
    while (n < 100) begin
      if (sck && !prev) rises++;
      prev = sck;
      if (rises == 5) break;
      @(negedge clk); n++;
    end
    cmp++; if (rises !== 5) begin errs++; $display("FAIL rmid_reach got %0d rises want 5", rises); end
    #1 reset = 1'b1;
    #1;
    cmp++; if (sck !== 1'b0) begin errs++; $display("FAIL rmid_sck got %b want 0", sck); end
    cmp++; if (cs_n !== 1'b1) begin errs++; $display("FAIL rmid_cs_n got %b want 1", cs_n); end
    cmp++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
    cmp++; if (bus.rx_data !== 16'h0000) begin errs++; $display("FAIL rmid_rx got %h want 0000", bus.rx_data); end
    @(negedge clk); @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    cmp++; if (dones !== 0) begin errs++; $display("FAIL rmid_no_done got %0d pulses want 0", dones); end
    capture(16'h5A5A, -10, lat, r, f, bad_ph, lead, cs_bad, cs_done, done_next, rx);
    cmp++; if (rx !== 16'h5A5A) begin errs++; $display("FAIL rmid_next_rx got %h want 5a5a", rx); end
    cmp++; if (lat !== 137) begin errs++; $display("FAIL rmid_next_lat got %0d want 137", lat); end
  endtask

  task automatic test_ignore_start();
    int lat, rises, falls, bad_ph, lead, cs_bad, busy_hits;
    logic cs_done, done_next;
    logic [15:0] rx;
    busy_hits = 0;
    loop = 1'b1;
    capture(16'h7E81, 40, lat, rises, falls, bad_ph, lead, cs_bad, cs_done, done_next, rx);
    cmp++; if (rx !== 16'h7E81) begin errs++; $display("FAIL ign_rx got %h want 7e81", rx); end
    cmp++; if (lat !== 137) begin errs++; $display("FAIL ign_latency got %0d want 137", lat); end
    cmp++; if (rises !== 16) begin errs++; $display("FAIL ign_rises got %0d want 16", rises); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.busy) busy_hits++;
    end
    cmp++; if (busy_hits !== 0) begin errs++; $display("FAIL ign_no_queue got %0d busy cycles want 0", busy_hits); end
  endtask

  initial begin
    bus.start = 1'b0; bus.tx_data = 16'h0000;
    bus2.start = 1'b0; bus2.tx_data = 16'h0000;
    loop = 1'b1;
    test_reset();
    test_loopback();
    test_responder();
    test_timing();
    test_back_to_back();
    test_reset_mid();
    test_ignore_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
